// File: rtl/mux_escritura_rtc.sv
// Merges write requests from the fecha/hora/crono edit controllers onto the
// single RTC write engine: per-source accept/buffer, fixed-priority arbiter, timeout.

module mux_escritura_rtc_src (
  input  logic       clk,
  input  logic       resetM,
  input  logic       req_i,
  input  logic [1:0] campo_i,
  input  logic [7:0] dato_i,
  input  logic       clr_i,
  output logic       ack_o,
  output logic       pend_o,
  output logic       bad_o,
  output logic [1:0] campo_o,
  output logic [7:0] dato_o
);
  logic       ack_q, pend_q;
  logic [1:0] campo_q;
  logic [7:0] dato_q;
  logic       acc;

  // A request is only looked at while nothing from this source is queued.
  assign acc   = req_i & ~pend_q;
  assign bad_o = acc & (campo_i == 2'd3);

  always_ff @(posedge clk or negedge resetM) begin
    if (!resetM) begin
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      campo_q <= 2'd0;
      dato_q  <= 8'd0;
    end else begin
      ack_q <= acc;
      if (acc && !bad_o) begin
        pend_q  <= 1'b1;
        campo_q <= campo_i;
        dato_q  <= dato_i;
      end else if (clr_i) begin
        pend_q <= 1'b0;
      end
    end
  end

  assign ack_o   = ack_q;
  assign pend_o  = pend_q;
  assign campo_o = campo_q;
  assign dato_o  = dato_q;
endmodule

module mux_escritura_rtc #(
  parameter int          TIMEOUT   = 255,
  parameter logic [7:0]  DIR_HORA  = 8'h21,
  parameter logic [7:0]  DIR_FECHA = 8'h24,
  parameter logic [7:0]  DIR_CR    = 8'h41
) (
  input  logic       clk,
  input  logic       resetM,
  input  logic       req_fecha,
  input  logic       req_hora,
  input  logic       req_cr,
  input  logic [1:0] campo_fecha,
  input  logic [1:0] campo_hora,
  input  logic [1:0] campo_cr,
  input  logic [7:0] dato_fecha,
  input  logic [7:0] dato_hora,
  input  logic [7:0] dato_cr,
  output logic       ack_fecha,
  output logic       ack_hora,
  output logic       ack_cr,
  output logic       wr_start,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic       wr_done,
  input  logic       clr_err,
  output logic       busy,
  output logic [2:0] err
);
  localparam int         NSRC    = 3;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  // Lane index matches the err bit: 2 = fecha, 1 = hora, 0 = crono.
  logic [NSRC-1:0]       req, ack, pend, bad, clr;
  logic [NSRC-1:0][1:0]  campo_in, campo_buf;
  logic [NSRC-1:0][7:0]  dato_in, dato_buf;

  state_t     state_q;
  logic [1:0] sel_q, sel_nxt;
  logic [7:0] cnt_q;
  logic       wr_start_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [2:0] err_q, err_set;
  logic       fin, tmo;

  assign req      = {req_fecha, req_hora, req_cr};
  assign campo_in = {campo_fecha, campo_hora, campo_cr};
  assign dato_in  = {dato_fecha, dato_hora, dato_cr};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    mux_escritura_rtc_src u_src (
      .clk     (clk),
      .resetM  (resetM),
      .req_i   (req[g]),
      .campo_i (campo_in[g]),
      .dato_i  (dato_in[g]),
      .clr_i   (clr[g]),
      .ack_o   (ack[g]),
      .pend_o  (pend[g]),
      .bad_o   (bad[g]),
      .campo_o (campo_buf[g]),
      .dato_o  (dato_buf[g])
    );
  end

  function automatic logic [7:0] base_addr(input logic [1:0] idx);
    case (idx)
      2'd2:    return DIR_FECHA;
      2'd1:    return DIR_HORA;
      default: return DIR_CR;
    endcase
  endfunction

  assign sel_nxt = pend[2] ? 2'd2 : (pend[1] ? 2'd1 : 2'd0);

  // A done arriving on the limit cycle still counts as success.
  assign fin     = (state_q == WAIT) && (wr_done || (cnt_q == TO_LAST));
  assign tmo     = (state_q == WAIT) && !wr_done && (cnt_q == TO_LAST);
  assign clr     = fin ? (3'b001 << sel_q) : 3'b000;
  assign err_set = (tmo ? (3'b001 << sel_q) : 3'b000) | bad;

  always_ff @(posedge clk or negedge resetM) begin
    if (!resetM) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      cnt_q      <= 8'd0;
      wr_start_q <= 1'b0;
      wr_addr_q  <= 8'd0;
      wr_data_q  <= 8'd0;
      err_q      <= 3'd0;
    end else begin
      err_q <= (clr_err ? 3'd0 : err_q) | err_set;
      case (state_q)
        IDLE: begin
          if (|pend) begin
            sel_q      <= sel_nxt;
            wr_start_q <= 1'b1;
            wr_addr_q  <= base_addr(sel_nxt) + {6'd0, campo_buf[sel_nxt]};
            wr_data_q  <= dato_buf[sel_nxt];
            state_q    <= START;
          end
        end
        START: begin
          wr_start_q <= 1'b0;
          cnt_q      <= 8'd0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (fin) state_q <= IDLE;
          else     cnt_q   <= cnt_q + 8'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {ack_fecha, ack_hora, ack_cr} = ack;
  assign wr_start = wr_start_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE) || (|pend);
endmodule

// File: tb/tb_mux_escritura_rtc.sv
// Self-checking bench for mux_escritura_rtc: vector table plus corner-case
// sequences; every wr_start is checked against a queue of expected writes.

module tb_mux_escritura_rtc;
  logic       clk = 1'b0;
  logic       resetM;
  logic       req_fecha, req_hora, req_cr;
  logic [1:0] campo_fecha, campo_hora, campo_cr;
  logic [7:0] dato_fecha, dato_hora, dato_cr;
  logic       ack_fecha, ack_hora, ack_cr;
  logic       wr_start;
  logic [7:0] wr_addr, wr_data;
  logic       wr_done, clr_err, busy;
  logic [2:0] err;

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  mux_escritura_rtc #(.TIMEOUT(8)) dut (
    .clk(clk), .resetM(resetM),
    .req_fecha(req_fecha), .req_hora(req_hora), .req_cr(req_cr),
    .campo_fecha(campo_fecha), .campo_hora(campo_hora), .campo_cr(campo_cr),
    .dato_fecha(dato_fecha), .dato_hora(dato_hora), .dato_cr(dato_cr),
    .ack_fecha(ack_fecha), .ack_hora(ack_hora), .ack_cr(ack_cr),
    .wr_start(wr_start), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_done(wr_done), .clr_err(clr_err), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every write start must match the oldest expected {addr,data}.
  always @(negedge clk) begin
    if (resetM === 1'b1 && wr_start === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_wr_start addr=%0h data=%0h", wr_addr, wr_data);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr_data", {16'd0, wr_addr, wr_data}, {16'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int src, input logic v, input logic [1:0] c, input logic [7:0] d);
    case (src)
      2: begin req_fecha = v; campo_fecha = c; dato_fecha = d; end
      1: begin req_hora  = v; campo_hora  = c; dato_hora  = d; end
      default: begin req_cr = v; campo_cr = c; dato_cr = d; end
    endcase
  endtask

  task automatic wait_start();
    for (int i = 0; i < 40; i++) begin
      if (wr_start === 1'b1) return;
      step();
    end
    checks++; failures++;
    $display("FAIL wait_start got=timeout expected=wr_start");
  endtask

  // Waits for the next write start, then answers with wr_done after dly cycles (dly>=1).
  task automatic serve(input int dly);
    wait_start();
    repeat (dly) step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
  endtask

  typedef struct {
    int         src;
    logic [1:0] campo;
    logic [7:0] dato;
    logic [7:0] addr;
    logic [2:0] ackm;
    int         dly;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{2, 2'd1, 8'h59, 8'h25, 3'b100, 2};
    vt[1] = '{2, 2'd2, 8'h12, 8'h26, 3'b100, 1};
    vt[2] = '{1, 2'd0, 8'h08, 8'h21, 3'b010, 4};
    vt[3] = '{0, 2'd1, 8'h99, 8'h42, 3'b001, 1};
    vt[4] = '{0, 2'd2, 8'h00, 8'h43, 3'b001, 7};
    vt[5] = '{1, 2'd1, 8'h45, 8'h22, 3'b010, 8};  // done on the timeout-limit cycle

    resetM = 1'b0; wr_done = 1'b0; clr_err = 1'b0;
    set_req(2, 1'b1, 2'd0, 8'h11);
    set_req(1, 1'b1, 2'd0, 8'h22);
    set_req(0, 1'b1, 2'd0, 8'h33);

    // Reset held with all requests high
    repeat (3) step();
    chk("rst_acks", {29'd0, ack_fecha, ack_hora, ack_cr}, 32'd0);
    chk("rst_wr_start", {31'd0, wr_start}, 32'd0);
    chk("rst_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);
    chk("rst_busy_err", {28'd0, busy, err}, 32'd0);
    resetM = 1'b1;
    exp_q.push_back({8'h24, 8'h11});
    exp_q.push_back({8'h21, 8'h22});
    exp_q.push_back({8'h41, 8'h33});
    step();
    chk("rel_acks", {29'd0, ack_fecha, ack_hora, ack_cr}, 32'b111);
    set_req(2, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 2'd0, 8'h00);
    set_req(0, 1'b0, 2'd0, 8'h00);
    serve(2); serve(2); serve(2);
    step();
    chk("rel_busy", {31'd0, busy}, 32'd0);

    // Single hora write with exact cycle timing
    set_req(1, 1'b1, 2'd2, 8'h15);
    exp_q.push_back({8'h23, 8'h15});
    step();
    chk("single_ack_c1", {29'd0, ack_fecha, ack_hora, ack_cr}, 32'b010);
    set_req(1, 1'b0, 2'd0, 8'h00);
    step();
    chk("single_start_c2", {31'd0, wr_start}, 32'd1);
    chk("single_addr_c2", {24'd0, wr_addr}, 32'h23);
    chk("single_ack_c2", {31'd0, ack_hora}, 32'd0);
    step(); step(); step();
    chk("single_addr_held", {16'd0, wr_addr, wr_data}, 32'h2315);
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("single_busy_c6", {31'd0, busy}, 32'd0);
    chk("single_err", {29'd0, err}, 32'd0);

    // Table of single writes
    for (int i = 0; i < 6; i++) begin
      set_req(vt[i].src, 1'b1, vt[i].campo, vt[i].dato);
      exp_q.push_back({vt[i].addr, vt[i].dato});
      step();
      chk($sformatf("vec%0d_ack", i), {29'd0, ack_fecha, ack_hora, ack_cr}, {29'd0, vt[i].ackm});
      set_req(vt[i].src, 1'b0, 2'd0, 8'h00);
      serve(vt[i].dly);
      chk($sformatf("vec%0d_busy_err", i), {28'd0, busy, err}, 32'd0);
    end

    // Contention: all three at once, served fecha, hora, cr
    set_req(2, 1'b1, 2'd0, 8'h07);
    set_req(1, 1'b1, 2'd1, 8'h30);
    set_req(0, 1'b1, 2'd0, 8'h45);
    exp_q.push_back({8'h24, 8'h07});
    exp_q.push_back({8'h22, 8'h30});
    exp_q.push_back({8'h41, 8'h45});
    step();
    chk("cont_acks", {29'd0, ack_fecha, ack_hora, ack_cr}, 32'b111);
    set_req(2, 1'b0, 2'd0, 8'h00);
    set_req(1, 1'b0, 2'd0, 8'h00);
    set_req(0, 1'b0, 2'd0, 8'h00);
    serve(3);
    chk("cont_busy_mid", {31'd0, busy}, 32'd1);
    serve(1); serve(2);
    chk("cont_busy_end", {28'd0, busy, err}, 32'd0);

    // Request held through the transaction: ignored while pending,
    // not accepted on the clearing edge, accepted on the next one
    set_req(2, 1'b1, 2'd0, 8'h77);
    exp_q.push_back({8'h24, 8'h77});
    step();
    chk("hold_ack1", {31'd0, ack_fecha}, 32'd1);
    step();
    chk("hold_noack_pend", {31'd0, ack_fecha}, 32'd0);
    step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    chk("hold_noack_clredge", {31'd0, ack_fecha}, 32'd0);
    exp_q.push_back({8'h24, 8'h77});
    step();
    chk("hold_ack2", {31'd0, ack_fecha}, 32'd1);
    set_req(2, 1'b0, 2'd0, 8'h00);
    serve(1);

    // Timeout: fecha write never completed
    set_req(2, 1'b1, 2'd0, 8'h01);
    exp_q.push_back({8'h24, 8'h01});
    step();
    set_req(2, 1'b0, 2'd0, 8'h00);
    wait_start();
    repeat (8) step();
    chk("tmo_busy_last_wait", {31'd0, busy}, 32'd1);
    step();
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    chk("tmo_err", {29'd0, err}, 32'b100);
    repeat (6) step();
    chk("tmo_err_sticky", {29'd0, err}, 32'b100);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("tmo_clr", {29'd0, err}, 32'd0);

    // Invalid field on crono: acked, no write, err bit set
    set_req(0, 1'b1, 2'd3, 8'h12);
    step();
    chk("inv_ack", {29'd0, ack_fecha, ack_hora, ack_cr}, 32'b001);
    set_req(0, 1'b0, 2'd0, 8'h00);
    step();
    chk("inv_err", {29'd0, err}, 32'b001);
    chk("inv_busy", {31'd0, busy}, 32'd0);
    repeat (4) step();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("inv_clr", {29'd0, err}, 32'd0);

    // Reset in the middle of WAIT, then a stale wr_done
    set_req(1, 1'b1, 2'd0, 8'h55);
    exp_q.push_back({8'h21, 8'h55});
    step();
    set_req(1, 1'b0, 2'd0, 8'h00);
    wait_start();
    step(); step();
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    resetM = 1'b0;
    #1;
    chk("mid_rst_addr_data", {16'd0, wr_addr, wr_data}, 32'd0);
    chk("mid_rst_busy_err_start", {27'd0, busy, err, wr_start}, 32'd0);
    step();
    resetM = 1'b1;
    step();
    wr_done = 1'b1;
    step();
    wr_done = 1'b0;
    repeat (10) step();
    chk("mid_after_busy_err", {28'd0, busy, err}, 32'd0);

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
